// File: rtl/rgb_fade_if.sv
// Control and LED-drive bundle between the fade sequencer and its host.
// PWM_BITS must match the sequencer instance that uses it.
interface rgb_fade_if #(
  parameter int PWM_BITS = 8
);
  logic                en;
  logic                mode;
  logic [PWM_BITS-1:0] bright;
  logic [2:0]          sector;
  logic                RGB_R;
  logic                RGB_G;
  logic                RGB_B;

  modport master (
    output en, mode, bright,
    input  sector, RGB_R, RGB_G, RGB_B
  );

  modport slave (
    input  en, mode, bright,
    output sector, RGB_R, RGB_G, RGB_B
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// RGB LED sequencer: six-colour step or hue-wheel crossfade, brightness-scaled PWM.
// Duties are latched only at the end of a PWM frame so colour changes never glitch mid-frame.
module rgb_fade_sequencer #(
  parameter int PERIOD_CYCLES = 12000000,
  parameter int PWM_BITS      = 8
) (
  input logic       clk,
  input logic       rst,
  rgb_fade_if.slave bus
);

  localparam int SECTOR_CYCLES = PERIOD_CYCLES / 6;
  localparam int SUB_CYCLES    = PERIOD_CYCLES / (6 * (2 ** PWM_BITS));
  localparam int TICK_W        = $clog2(SECTOR_CYCLES);
  localparam int PROD_W        = 2 * PWM_BITS + 1;

  localparam logic [TICK_W-1:0]   SECTOR_TERM = TICK_W'(SECTOR_CYCLES - 1);
  localparam logic [TICK_W-1:0]   SUB_TERM    = TICK_W'(SUB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DMAX        = {PWM_BITS{1'b1}};

  typedef enum logic [2:0] {
    SEC0 = 3'd0,
    SEC1 = 3'd1,
    SEC2 = 3'd2,
    SEC3 = 3'd3,
    SEC4 = 3'd4,
    SEC5 = 3'd5
  } sector_t;

  // bright+1 makes all-ones an exact pass-through and zero a full blank
  function automatic logic [PWM_BITS-1:0] scale_duty(
    input logic [PWM_BITS-1:0] duty,
    input logic [PWM_BITS-1:0] level
  );
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(duty) * (PROD_W'(level) + PROD_W'(1'b1));
    return PWM_BITS'(prod >> PWM_BITS);
  endfunction

  sector_t             sector_r;
  sector_t             sector_nx_s;
  logic [TICK_W-1:0]   tick_r;
  logic [TICK_W-1:0]   tick_nx_s;
  logic [PWM_BITS-1:0] frac_r;
  logic [PWM_BITS-1:0] frac_nx_s;
  logic                mode_r;
  logic                mode_chg_s;
  logic                tick_hit_s;
  logic                adv_s;

  logic [PWM_BITS-1:0] duty_r_s;
  logic [PWM_BITS-1:0] duty_g_s;
  logic [PWM_BITS-1:0] duty_b_s;
  logic [PWM_BITS-1:0] scaled_r_s;
  logic [PWM_BITS-1:0] scaled_g_s;
  logic [PWM_BITS-1:0] scaled_b_s;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] live_r_r;
  logic [PWM_BITS-1:0] live_g_r;
  logic [PWM_BITS-1:0] live_b_r;
  logic                rgb_r_r;
  logic                rgb_g_r;
  logic                rgb_b_r;

  // Sequencer state register: hue sector, tick counter, fade fraction, mode copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sector_r <= SEC0;
      tick_r   <= '0;
      frac_r   <= '0;
      mode_r   <= 1'b0;
    end else begin
      sector_r <= sector_nx_s;
      tick_r   <= tick_nx_s;
      frac_r   <= frac_nx_s;
      mode_r   <= bus.mode;
    end
  end

  // Next-state logic: a mode change restarts timing and suppresses a coincident advance
  always_comb begin
    sector_nx_s = sector_r;
    tick_nx_s   = tick_r;
    frac_nx_s   = frac_r;
    mode_chg_s  = (bus.mode != mode_r);
    tick_hit_s  = (tick_r == (mode_r ? SUB_TERM : SECTOR_TERM));
    adv_s       = bus.en & tick_hit_s & ~mode_chg_s;

    if (mode_chg_s) begin
      tick_nx_s = '0;
      frac_nx_s = '0;
    end else if (bus.en) begin
      tick_nx_s = tick_hit_s ? '0 : (tick_r + TICK_W'(1'b1));
    end else begin
      tick_nx_s = tick_r;
    end

    if (adv_s && mode_r) begin
      frac_nx_s = (frac_r == DMAX) ? '0 : (frac_r + PWM_BITS'(1'b1));
    end else begin
      frac_nx_s = frac_nx_s;
    end

    if (adv_s && (!mode_r || (frac_r == DMAX))) begin
      case (sector_r)
        SEC0:    sector_nx_s = SEC1;
        SEC1:    sector_nx_s = SEC2;
        SEC2:    sector_nx_s = SEC3;
        SEC3:    sector_nx_s = SEC4;
        SEC4:    sector_nx_s = SEC5;
        SEC5:    sector_nx_s = SEC0;
        default: sector_nx_s = SEC0;
      endcase
    end else begin
      sector_nx_s = sector_r;
    end
  end

  // Target colour: fixed palette in step mode, hue-wheel ramp on frac in fade mode
  always_comb begin
    duty_r_s = '0;
    duty_g_s = '0;
    duty_b_s = '0;
    if (!mode_r) begin
      case (sector_r)
        SEC0: duty_r_s = DMAX;
        SEC1: duty_g_s = DMAX;
        SEC2: duty_b_s = DMAX;
        SEC3: begin duty_r_s = DMAX; duty_g_s = DMAX; end
        SEC4: begin duty_g_s = DMAX; duty_b_s = DMAX; end
        SEC5: begin duty_r_s = DMAX; duty_b_s = DMAX; end
        default: duty_r_s = '0;
      endcase
    end else begin
      case (sector_r)
        SEC0: begin duty_r_s = DMAX;          duty_g_s = frac_r; end
        SEC1: begin duty_r_s = DMAX - frac_r; duty_g_s = DMAX;   end
        SEC2: begin duty_g_s = DMAX;          duty_b_s = frac_r; end
        SEC3: begin duty_g_s = DMAX - frac_r; duty_b_s = DMAX;   end
        SEC4: begin duty_r_s = frac_r;        duty_b_s = DMAX;   end
        SEC5: begin duty_r_s = DMAX;          duty_b_s = DMAX - frac_r; end
        default: duty_r_s = '0;
      endcase
    end
  end

  assign scaled_r_s = scale_duty(duty_r_s, bus.bright);
  assign scaled_g_s = scale_duty(duty_g_s, bus.bright);
  assign scaled_b_s = scale_duty(duty_b_s, bus.bright);

  // PWM engine: free-running counter, frame-synchronous duty load, registered drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r <= '0;
      live_r_r  <= '0;
      live_g_r  <= '0;
      live_b_r  <= '0;
      rgb_r_r   <= 1'b0;
      rgb_g_r   <= 1'b0;
      rgb_b_r   <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
      if (pwm_cnt_r == DMAX) begin
        live_r_r <= scaled_r_s;
        live_g_r <= scaled_g_s;
        live_b_r <= scaled_b_s;
      end else begin
        live_r_r <= live_r_r;
        live_g_r <= live_g_r;
        live_b_r <= live_b_r;
      end
      // Full-scale duty is forced solid so the LED never blinks off for one slot
      rgb_r_r <= (live_r_r == DMAX) | (pwm_cnt_r < live_r_r);
      rgb_g_r <= (live_g_r == DMAX) | (pwm_cnt_r < live_g_r);
      rgb_b_r <= (live_b_r == DMAX) | (pwm_cnt_r < live_b_r);
    end
  end

  assign bus.sector = sector_r;
  assign bus.RGB_R  = rgb_r_r;
  assign bus.RGB_G  = rgb_g_r;
  assign bus.RGB_B  = rgb_b_r;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer (PERIOD_CYCLES=6144, PWM_BITS=4).
// Expected observations are queued when stimulus is applied and popped when measured.
module tb_rgb_fade_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rgb_fade_if #(.PWM_BITS(4)) bus ();

  rgb_fade_sequencer #(.PERIOD_CYCLES(6144), .PWM_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sector;
    int r;
    int g;
    int b;
  } obs_t;

  typedef struct {
    int          sector;
    logic [3:0]  bright;
    int          r;
    int          g;
    int          b;
  } vec_t;

  obs_t sb[$];
  int   sq[$];
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_obs(input int s, input int r, input int g, input int b);
    obs_t o;
    o.sector = s; o.r = r; o.g = g; o.b = b;
    sb.push_back(o);
  endtask

  // count high samples per channel over one 16-cycle window, compare with queued expectation
  task automatic measure(input string name);
    obs_t e;
    int r, g, b, s;
    r = 0; g = 0; b = 0;
    s = int'(bus.sector);
    repeat (16) begin
      @(posedge clk); #1;
      r += int'(bus.RGB_R);
      g += int'(bus.RGB_G);
      b += int'(bus.RGB_B);
    end
    if (sb.size() == 0) begin
      chk({name, " queue"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({name, " sector"}, s, e.sector);
      chk({name, " R"}, r, e.r);
      chk({name, " G"}, g, e.g);
      chk({name, " B"}, b, e.b);
    end
  endtask

  task automatic wait_change(output int n);
    logic [2:0] prev;
    prev = bus.sector;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.sector == prev && n < 8000);
  endtask

  task automatic do_reset(input logic m, input logic e, input logic [3:0] b);
    rst = 1'b1;
    bus.en = 1'b0;
    bus.mode = 1'b0;
    bus.bright = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mode = m;
    bus.en = e;
    bus.bright = b;
  endtask

  initial begin
    int n;
    int total;
    int exp_s;

    tbl[0] = '{0, 4'd15, 16, 0, 0};
    tbl[1] = '{0, 4'd7,  7,  0, 0};
    tbl[2] = '{0, 4'd0,  0,  0, 0};
    tbl[3] = '{1, 4'd8,  0,  8, 0};
    tbl[4] = '{2, 4'd1,  0,  0, 1};
    tbl[5] = '{3, 4'd15, 16, 16, 0};
    tbl[6] = '{3, 4'd10, 10, 10, 0};
    tbl[7] = '{4, 4'd3,  0,  3, 3};
    tbl[8] = '{5, 4'd15, 16, 0, 16};

    // Reset state, first dark frame, then step sequence timing
    do_reset(1'b0, 1'b1, 4'd15);
    chk("reset sector", int'(bus.sector), 0);
    chk("reset RGB", int'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 0);
    expect_obs(0, 0, 0, 0);
    measure("first frame");
    expect_obs(0, 16, 0, 0);
    measure("second frame");
    for (int i = 1; i <= 6; i++) sq.push_back(i % 6);
    total = 32;
    for (int i = 0; i < 6; i++) begin
      wait_change(n);
      total += n;
      exp_s = sq.pop_front();
      chk("step sector", int'(bus.sector), exp_s);
      chk("step interval", total, 1024);
      total = 0;
    end

    // Palette and brightness table, frozen in each sector with en=0
    do_reset(1'b0, 1'b0, 4'd15);
    for (int i = 0; i < 9; i++) begin
      if (int'(bus.sector) != tbl[i].sector) begin
        bus.en = 1'b1;
        n = 0;
        while (int'(bus.sector) != tbl[i].sector && n < 8000) begin
          @(posedge clk); #1;
          n++;
        end
        bus.en = 1'b0;
      end
      bus.bright = tbl[i].bright;
      expect_obs(tbl[i].sector, tbl[i].r, tbl[i].g, tbl[i].b);
      repeat (40) @(posedge clk);
      #1;
      measure("table");
    end

    // Fade: frac=4 in sector 0, then sector 1 and full wrap timing
    do_reset(1'b1, 1'b1, 4'd15);
    repeat (288) @(posedge clk);
    #1;
    bus.en = 1'b0;
    expect_obs(0, 16, 4, 0);
    repeat (40) @(posedge clk);
    #1;
    measure("fade frac4");
    bus.en = 1'b1;
    wait_change(n);
    chk("fade to s1 cycles", n, 737);
    chk("fade s1", int'(bus.sector), 1);
    total = 288 + n;
    for (int k = 0; k < 5; k++) begin
      wait_change(n);
      total += n;
      chk("fade sector", int'(bus.sector), (k + 2) % 6);
    end
    chk("fade wrap cycles", total, 6145);

    // Mode toggle coinciding with a step advance
    do_reset(1'b0, 1'b1, 4'd15);
    repeat (1023) @(posedge clk);
    #1;
    bus.mode = 1'b1;
    @(posedge clk); #1;
    chk("toggle no adv", int'(bus.sector), 0);
    bus.en = 1'b0;
    expect_obs(0, 16, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    measure("toggle frac0");
    bus.en = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    bus.en = 1'b0;
    expect_obs(0, 16, 1, 0);
    repeat (40) @(posedge clk);
    #1;
    measure("toggle next adv");

    // Long pause mid-sector, resume, then asynchronous reset mid-frame
    do_reset(1'b0, 1'b1, 4'd15);
    repeat (500) @(posedge clk);
    #1;
    bus.en = 1'b0;
    expect_obs(0, 16, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    measure("pause start");
    repeat (3000) @(posedge clk);
    #1;
    expect_obs(0, 16, 0, 0);
    measure("pause end");
    bus.en = 1'b1;
    wait_change(n);
    chk("resume cycles", n, 524);
    chk("resume sector", int'(bus.sector), 1);
    expect_obs(1, 0, 16, 0);
    repeat (40) @(posedge clk);
    #1;
    measure("sector1 green");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst sector", int'(bus.sector), 0);
    chk("async rst RGB", int'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
